// File: rtl/hdr_insert_sched.sv
// Header scheduler: round-robin grants one requester's header per upstream packet.
// The header goes out on the inserter's insert port first. Exactly one packet is
// then gated through, so packet data can never overtake its header.
module hdr_insert_sched #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned GNT_WD       = $clog2(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ*DATA_WD-1:0]           req_data,
  input  logic [NUM_REQ*DATA_BYTE_WD-1:0]      req_keep,
  input  logic [NUM_REQ*(BYTE_CNT_WD+1)-1:0]   req_byte_cnt,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [DATA_WD-1:0]                   s_data,
  input  logic [DATA_BYTE_WD-1:0]              s_keep,
  input  logic                                 s_last,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [DATA_WD-1:0]                   m_data,
  output logic [DATA_BYTE_WD-1:0]              m_keep,
  output logic                                 m_last,
  output logic                                 ins_valid,
  input  logic                                 ins_ready,
  output logic [DATA_WD-1:0]                   ins_data,
  output logic [DATA_BYTE_WD-1:0]              ins_keep,
  output logic [BYTE_CNT_WD:0]                 ins_byte_cnt,
  output logic [GNT_WD-1:0]                    grant_id,
  output logic                                 busy,
  output logic                                 cfg_err,
  output logic [15:0]                          pkt_cnt
);

  localparam int unsigned CNT_WD = BYTE_CNT_WD + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PKT  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [GNT_WD-1:0]       rr_ptr;
  logic [GNT_WD-1:0]       win_idx;
  logic                    win_found;
  logic [DATA_WD-1:0]      sel_data;
  logic [DATA_BYTE_WD-1:0] sel_keep;
  logic [CNT_WD-1:0]       sel_cnt;
  logic                    cnt_clamp;
  logic [CNT_WD-1:0]       cnt_lat;
  logic                    grant_fire;
  logic                    pkt_done;
  logic [DATA_WD-1:0]      hdr_data_q;
  logic [DATA_BYTE_WD-1:0] hdr_keep_q;
  logic [CNT_WD-1:0]       hdr_cnt_q;
  logic [GNT_WD-1:0]       grant_id_q;
  logic                    cfg_err_q;
  logic [15:0]             pkt_cnt_q;

  // Round-robin search: lowest valid index at or above rr_ptr, else lowest valid overall.
  // Grants are withheld while in reset so a requester is never told it was accepted
  // by a cycle that will not latch its header.
  always_comb begin
    logic              hi_found;
    logic [GNT_WD-1:0] hi_idx;
    logic              lo_found;
    logic [GNT_WD-1:0] lo_idx;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = GNT_WD'(i);
        if (GNT_WD'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = GNT_WD'(i);
        end
      end
    end
    win_found = lo_found && rst_n;
    win_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Mux the winner's header fields and clamp an oversized byte count.
  always_comb begin
    sel_data = '0;
    sel_keep = '0;
    sel_cnt  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win_idx == GNT_WD'(i)) begin
        sel_data = req_data[i*DATA_WD +: DATA_WD];
        sel_keep = req_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        sel_cnt  = req_byte_cnt[i*CNT_WD +: CNT_WD];
      end
    end
    cnt_clamp = (sel_cnt > CNT_WD'(DATA_BYTE_WD));
    cnt_lat   = cnt_clamp ? CNT_WD'(DATA_BYTE_WD) : sel_cnt;
  end

  assign grant_fire = (state == IDLE) && win_found;
  assign pkt_done   = (state == PKT) && s_valid && m_ready && s_last;

  // Next state and handshake/pass-through outputs.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_keep    = '0;
    m_last    = 1'b0;
    ins_valid = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          state_nxt = (sel_cnt == '0) ? PKT : HDR;
        end
      end
      HDR: begin
        ins_valid = 1'b1;
        if (ins_ready) state_nxt = PKT;
      end
      PKT: begin
        m_valid = s_valid;
        s_ready = m_ready;
        m_data  = s_data;
        m_keep  = s_keep;
        m_last  = s_last;
        if (s_valid && m_ready && s_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grant bookkeeping: latch header, advance round-robin pointer, flag clamps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      grant_id_q <= '0;
      hdr_data_q <= '0;
      hdr_keep_q <= '0;
      hdr_cnt_q  <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_err_q <= grant_fire && cnt_clamp;
      if (grant_fire) begin
        grant_id_q <= win_idx;
        rr_ptr     <= (win_idx == GNT_WD'(NUM_REQ - 1)) ? '0 : win_idx + GNT_WD'(1);
        hdr_data_q <= sel_data;
        hdr_keep_q <= sel_keep;
        hdr_cnt_q  <= cnt_lat;
      end
    end
  end

  // Completed-packet counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n)        pkt_cnt_q <= '0;
    else if (pkt_done) pkt_cnt_q <= pkt_cnt_q + 16'd1;
  end

  assign ins_data     = hdr_data_q;
  assign ins_keep     = hdr_keep_q;
  assign ins_byte_cnt = hdr_cnt_q;
  assign grant_id     = grant_id_q;
  assign cfg_err      = cfg_err_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_hdr_insert_sched.sv
// Scoreboard bench for hdr_insert_sched: expected grants, headers and beats are
// queued as stimulus is issued and popped when the DUT hands them off.
module tb_hdr_insert_sched;

  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int CW  = 3;
  localparam int NR  = 2;
  localparam int GW  = 1;
  localparam int TMO = 200;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [BW-1:0] keep;
    logic [CW-1:0] cnt;
  } hdr_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [BW-1:0] keep;
    logic [CW-1:0] cnt;
    logic          gnt;
  } xhdr_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [BW-1:0] keep;
    logic          last;
  } beat_t;

  logic clk;
  logic rst_n;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_ready;
  logic [NR*DW-1:0]   req_data;
  logic [NR*BW-1:0]   req_keep;
  logic [NR*CW-1:0]   req_byte_cnt;
  logic               s_valid;
  logic               s_ready;
  logic [DW-1:0]      s_data;
  logic [BW-1:0]      s_keep;
  logic               s_last;
  logic               m_valid;
  logic               m_ready;
  logic [DW-1:0]      m_data;
  logic [BW-1:0]      m_keep;
  logic               m_last;
  logic               ins_valid;
  logic               ins_ready;
  logic [DW-1:0]      ins_data;
  logic [BW-1:0]      ins_keep;
  logic [CW-1:0]      ins_byte_cnt;
  logic [GW-1:0]      grant_id;
  logic               busy;
  logic               cfg_err;
  logic [15:0]        pkt_cnt;

  logic          rv [NR];
  logic [DW-1:0] rd [NR];
  logic [BW-1:0] rk [NR];
  logic [CW-1:0] rc [NR];

  hdr_t  q0 [$];
  hdr_t  q1 [$];
  xhdr_t exp_hdr [$];
  beat_t exp_beats [$];
  int    exp_gnt [$];

  int  n_checks = 0;
  int  n_errors = 0;
  int  n_sent   = 0;
  int  rr_cyc   = 0;
  int  ins_cyc  = 0;
  int  cfg_cyc  = 0;
  logic mon_en   = 1'b0;
  logic m_toggle = 1'b0;
  logic m_hold   = 1'b1;
  logic was_pkt  = 1'b0;
  logic was_end  = 1'b0;

  hdr_insert_sched #(
    .DATA_WD(DW), .DATA_BYTE_WD(BW), .BYTE_CNT_WD(CW-1), .NUM_REQ(NR), .GNT_WD(GW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_keep(req_keep), .req_byte_cnt(req_byte_cnt),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data), .ins_keep(ins_keep),
    .ins_byte_cnt(ins_byte_cnt), .grant_id(grant_id), .busy(busy), .cfg_err(cfg_err),
    .pkt_cnt(pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack per-requester drive variables onto the flat request bus.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_valid[i]              = rv[i];
      req_data[i*DW +: DW]      = rd[i];
      req_keep[i*BW +: BW]      = rk[i];
      req_byte_cnt[i*CW +: CW]  = rc[i];
    end
  end

  // Downstream ready: either held at m_hold or toggled every cycle.
  always begin
    @(posedge clk); #1;
    if (m_toggle) m_ready = ~m_ready;
    else          m_ready = m_hold;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic hdr_t qhead(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic add_req(input int i, input logic [DW-1:0] d, input logic [BW-1:0] k,
                         input logic [CW-1:0] c);
    hdr_t h;
    h.data = d; h.keep = k; h.cnt = c;
    if (i == 0) q0.push_back(h);
    else        q1.push_back(h);
  endtask

  // Expected grant in order; headers with a zero byte count are never offered.
  task automatic expect_grant(input int i, input logic [DW-1:0] d, input logic [BW-1:0] k,
                              input logic [CW-1:0] c);
    xhdr_t x;
    exp_gnt.push_back(i);
    if (c != '0) begin
      x.data = d; x.keep = k; x.gnt = (i != 0);
      x.cnt  = (c > CW'(BW)) ? CW'(BW) : c;
      exp_hdr.push_back(x);
    end
  endtask

  // Requester model: presents its queue head and holds it until accepted.
  task automatic serve(input int i);
    hdr_t h;
    int   t;
    rv[i] = 1'b0; rd[i] = '0; rk[i] = '0; rc[i] = '0;
    forever begin
      @(posedge clk); #1;
      if (qsize(i) == 0) begin
        rv[i] = 1'b0;
      end else begin
        h = qhead(i);
        rv[i] = 1'b1; rd[i] = h.data; rk[i] = h.keep; rc[i] = h.cnt;
        t = 0;
        do begin @(negedge clk); t++; end while (!req_ready[i] && t < TMO);
        if (!req_ready[i]) check("req_timeout", 64'd0, 64'd1);
        qpop(i);
      end
    end
  endtask

  initial serve(0);
  initial serve(1);

  // Output monitor sampled on the falling edge.
  always @(negedge clk) begin
    beat_t b;
    xhdr_t x;
    int    gi;
    if (!mon_en) begin
      was_pkt = 1'b0;
      was_end = 1'b0;
    end else begin
      if (was_pkt) check(was_end ? "pkt_exit" : "pkt_hold", 64'(busy), 64'(!was_end));
      if (|req_ready) begin
        rr_cyc++;
        check("rr_onehot", 64'($onehot(req_ready)), 64'd1);
        gi = req_ready[1] ? 1 : 0;
        if (exp_gnt.size() == 0) check("gnt_unexp", 64'd1, 64'd0);
        else                     check("gnt_id", 64'(gi), 64'(exp_gnt.pop_front()));
      end
      if (ins_valid) begin
        ins_cyc++;
        check("hdr_gate", 64'({s_ready, m_valid}), 64'd0);
      end
      if (ins_valid && ins_ready) begin
        if (exp_hdr.size() == 0) begin
          check("hdr_unexp", 64'd1, 64'd0);
        end else begin
          x = exp_hdr.pop_front();
          check("hdr_data", 64'(ins_data), 64'(x.data));
          check("hdr_keep", 64'(ins_keep), 64'(x.keep));
          check("hdr_cnt",  64'(ins_byte_cnt), 64'(x.cnt));
          check("hdr_gid",  64'(grant_id), 64'(x.gnt));
        end
      end
      if (!busy || ins_valid)
        check("m_idle_zero", 64'({m_valid, m_last, m_keep, m_data}), 64'd0);
      if (busy && !ins_valid)
        check("pass_thru", 64'({m_valid, s_ready}), 64'({s_valid, m_ready}));
      if (m_valid && m_ready) begin
        if (exp_beats.size() == 0) begin
          check("beat_unexp", 64'd1, 64'd0);
        end else begin
          b = exp_beats.pop_front();
          check("beat_data", 64'(m_data), 64'(b.data));
          check("beat_keep", 64'(m_keep), 64'(b.keep));
          check("beat_last", 64'(m_last), 64'(b.last));
        end
      end
      if (cfg_err) cfg_cyc++;
      was_pkt = busy && !ins_valid;
      was_end = was_pkt && s_valid && m_ready && s_last;
    end
  end

  task automatic send_pkt(input int nb, input logic [DW-1:0] base);
    beat_t b;
    int    t;
    for (int i = 0; i < nb; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_data  = base + DW'(i);
      s_keep  = (i == nb - 1) ? 4'h3 : 4'hF;
      s_last  = (i == nb - 1);
      b.data = s_data; b.keep = s_keep; b.last = s_last;
      exp_beats.push_back(b);
      t = 0;
      do begin @(negedge clk); t++; end while (!s_ready && t < TMO);
      if (!s_ready) begin
        check("s_hs_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    n_sent++;
  endtask

  task automatic wait_idle();
    int   t;
    logic pend;
    t = 0;
    do begin
      @(negedge clk); t++;
      pend = busy || (exp_beats.size() != 0) || (exp_hdr.size() != 0) ||
             (exp_gnt.size() != 0) || (q0.size() != 0) || (q1.size() != 0);
    end while (pend && t < TMO);
    check("idle_timeout", 64'(pend), 64'd0);
  endtask

  task automatic clear_sb();
    exp_beats.delete(); exp_hdr.delete(); exp_gnt.delete();
    n_sent = 0; rr_cyc = 0; ins_cyc = 0; cfg_cyc = 0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_state", 64'({busy, ins_valid, m_valid, s_ready, cfg_err, req_ready, grant_id}), 64'd0);
    check("rst_ins", 64'({ins_data, ins_keep, ins_byte_cnt}), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    clear_sb();
    @(posedge clk); #1; rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    int t;
    rst_n = 1'b0; ins_ready = 1'b1;
    s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    do_reset();

    // Single requester, 3-byte header, 4-beat packet.
    expect_grant(0, 32'hA5A5A5A5, 4'h7, 3'd3);
    add_req(0, 32'hA5A5A5A5, 4'h7, 3'd3);
    send_pkt(4, 32'h1000);
    wait_idle();
    check("t1_pkt_cnt", 64'(pkt_cnt), 64'(n_sent));
    check("t1_rr_cyc", 64'(rr_cyc), 64'd1);
    check("t1_ins_cyc", 64'(ins_cyc), 64'd1);

    // Both requesters held valid: grants alternate from requester 0.
    do_reset();
    expect_grant(0, 32'h00000A01, 4'hF, 3'd4);
    expect_grant(1, 32'h00000B01, 4'h3, 3'd2);
    expect_grant(0, 32'h00000A02, 4'hF, 3'd1);
    expect_grant(1, 32'h00000B02, 4'h1, 3'd4);
    add_req(0, 32'h00000A01, 4'hF, 3'd4);
    add_req(0, 32'h00000A02, 4'hF, 3'd1);
    add_req(1, 32'h00000B01, 4'h3, 3'd2);
    add_req(1, 32'h00000B02, 4'h1, 3'd4);
    for (int p = 0; p < 4; p++) send_pkt(1, 32'h2000 + DW'(p * 16));
    wait_idle();
    check("t2_pkt_cnt", 64'(pkt_cnt), 64'd4);
    check("t2_rr_cyc", 64'(rr_cyc), 64'd4);

    // Inserter stalls the header for 5 cycles while upstream data waits.
    ins_ready = 1'b0;
    expect_grant(0, 32'h3C3C3C3C, 4'hF, 3'd4);
    add_req(0, 32'h3C3C3C3C, 4'hF, 3'd4);
    fork
      send_pkt(2, 32'h3000);
      begin
        t = 0;
        do begin @(negedge clk); t++; end while (!ins_valid && t < TMO);
        check("t3_ins_seen", 64'(ins_valid), 64'd1);
        for (int c = 0; c < 5; c++) begin
          if (c > 0) @(negedge clk);
          check("t3_gate", 64'({s_ready, m_valid, ins_valid}), 64'b001);
          check("t3_hold", 64'({ins_data, ins_byte_cnt}), 64'({32'h3C3C3C3C, 3'd4}));
        end
        @(posedge clk); #1; ins_ready = 1'b1;
      end
    join
    wait_idle();
    check("t3_pkt_cnt", 64'(pkt_cnt), 64'(n_sent));

    // Zero byte count: no header, packet passes directly.
    ins_cyc = 0; cfg_cyc = 0;
    expect_grant(0, 32'hDEADBEEF, 4'hF, 3'd0);
    add_req(0, 32'hDEADBEEF, 4'hF, 3'd0);
    send_pkt(2, 32'h4000);
    wait_idle();
    check("t4_no_hdr", 64'(ins_cyc), 64'd0);
    check("t4_no_err", 64'(cfg_cyc), 64'd0);

    // Oversized byte count clamps to the beat width and pulses cfg_err once.
    expect_grant(1, 32'h77665544, 4'hF, 3'd7);
    add_req(1, 32'h77665544, 4'hF, 3'd7);
    send_pkt(1, 32'h4100);
    wait_idle();
    check("t4_cfg_err", 64'(cfg_cyc), 64'd1);
    check("t4_clamp", 64'(ins_byte_cnt), 64'd4);
    check("t4_pkt_cnt", 64'(pkt_cnt), 64'(n_sent));

    // Downstream ready toggling across a 6-beat packet.
    expect_grant(0, 32'h5A5A0006, 4'h3, 3'd2);
    add_req(0, 32'h5A5A0006, 4'h3, 3'd2);
    m_toggle = 1'b1;
    send_pkt(6, 32'h5000);
    m_toggle = 1'b0;
    wait_idle();
    check("t5_pkt_cnt", 64'(pkt_cnt), 64'(n_sent));

    // Reset mid-packet on beat 2, then check state and round-robin pointer clear.
    mon_en = 1'b0;
    add_req(0, 32'h66666666, 4'hF, 3'd1);
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 32'h6000; s_keep = 4'hF; s_last = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!s_ready && t < TMO);
    check("t6_beat1", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    s_data = 32'h6001; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    check("t6_state", 64'({busy, ins_valid, m_valid, s_ready, cfg_err, grant_id}), 64'd0);
    check("t6_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("t6_ins", 64'({ins_data, ins_keep, ins_byte_cnt}), 64'd0);
    clear_sb();
    mon_en = 1'b1;
    expect_grant(0, 32'h6A000000, 4'hF, 3'd4);
    expect_grant(1, 32'h6B000000, 4'hF, 3'd4);
    add_req(0, 32'h6A000000, 4'hF, 3'd4);
    add_req(1, 32'h6B000000, 4'hF, 3'd4);
    send_pkt(1, 32'h6100);
    send_pkt(2, 32'h6200);
    wait_idle();
    check("t6_after_cnt", 64'(pkt_cnt), 64'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hdr_insert_sched.md
Name: hdr_insert_sched

Overview:
Per-packet header scheduler in front of the AXI-Stream header inserter. Arbitrates round-robin among NUM_REQ header requesters and binds one granted header to the next upstream packet. Presents the header on the inserter's insert port, then gates exactly one packet (through its last beat) from upstream to the inserter's data port. Guarantees one header per packet and prevents packet data from overtaking its header.

Parameters:
DATA_WD, 32, stream and header data width in bits
DATA_BYTE_WD, DATA_WD/8, bytes per beat (keep width)
BYTE_CNT_WD, $clog2(DATA_BYTE_WD), header byte count is BYTE_CNT_WD+1 bits
NUM_REQ, 2, number of header requesters (>=2)
GNT_WD, $clog2(NUM_REQ), grant index width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
req_valid  in  NUM_REQ  per-requester header valid
req_ready  out  NUM_REQ  per-requester accept, combinational one-hot
req_data  in  NUM_REQ*DATA_WD  packed headers, requester i at [i*DATA_WD +: DATA_WD]
req_keep  in  NUM_REQ*DATA_BYTE_WD  packed header keeps
req_byte_cnt  in  NUM_REQ*(BYTE_CNT_WD+1)  packed header byte counts
s_valid  in  1  upstream data valid
s_ready  out  1  upstream data ready
s_data  in  DATA_WD  upstream data
s_keep  in  DATA_BYTE_WD  upstream keep
s_last  in  1  upstream last beat
m_valid  out  1  to inserter data valid
m_ready  in  1  inserter data ready
m_data  out  DATA_WD  to inserter data
m_keep  out  DATA_BYTE_WD  to inserter keep
m_last  out  1  to inserter last
ins_valid  out  1  header valid to inserter
ins_ready  in  1  inserter header ready
ins_data  out  DATA_WD  latched header data
ins_keep  out  DATA_BYTE_WD  latched header keep
ins_byte_cnt  out  BYTE_CNT_WD+1  latched, clamped byte count
grant_id  out  GNT_WD  index of current granted requester
busy  out  1  high in HDR or PKT
cfg_err  out  1  one-cycle pulse on clamped byte count
pkt_cnt  out  16  completed packets, wraps at 65535->0

Behaviour:
- FSM states: IDLE, HDR, PKT.
- IDLE: s_ready=0, m_valid=0, ins_valid=0. If any req_valid, winner = first set bit searching from rr_ptr upward, wrapping. req_ready[winner]=1 combinationally (only in IDLE, only the winner). On that edge: latch winner's data/keep/byte_cnt, grant_id<=winner, rr_ptr<=(winner+1) mod NUM_REQ.
- Byte count on latch: 0 -> next state PKT directly (packet passes headerless, no ins_valid). 1..DATA_BYTE_WD -> next HDR. >DATA_BYTE_WD -> store DATA_BYTE_WD, cfg_err pulses the cycle after the latch edge, next HDR.
- HDR: ins_valid=1 holding latched values stable until ins_ready. On ins_valid&&ins_ready -> PKT. s_ready=0 throughout HDR.
- PKT: combinational pass-through: m_valid=s_valid, s_ready=m_ready, m_data/m_keep/m_last = s_data/s_keep/s_last. On s_valid&&m_ready&&s_last -> IDLE, pkt_cnt+1. Non-last beats stay in PKT.
- In IDLE and HDR: m_valid=0 and m_data/m_keep/m_last driven 0.
- Minimum per-packet cost: 1 cycle IDLE grant + >=1 cycle HDR + >=1 beat PKT. There is no grant in the last-beat cycle; the next grant occurs in the following IDLE cycle.
- Requesters not granted see req_ready=0 and must hold req_valid and header values stable (AXI rule); the block never drops a held request.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...
- Reset (rst_n=0 at edge), including mid-HDR or mid-PKT: state IDLE, rr_ptr=0, grant_id=0, latched header regs=0, pkt_cnt=0, cfg_err=0; all outputs 0 (ins_* = 0, busy=0). A packet cut mid-flight is abandoned; the inserter is reset alongside.
- busy = (state!=IDLE), combinational from state register.

Test Plan:
- Single requester 0, byte_cnt=3, hdr=0xA5A5A5A5, 4-beat packet, m_ready=ins_ready=1 -> req_ready[0] 1 cycle, ins_valid 1 cycle with 0xA5A5A5A5/cnt 3, 4 beats passed in order, m_last on beat 4, pkt_cnt=1, back to IDLE.
- Both requesters held valid, 4 one-beat packets -> grant_id sequence 0,1,0,1; req_ready never asserted on two bits at once; pkt_cnt=4.
- ins_ready held 0 for 5 cycles with s_valid=1 -> s_ready=0 and m_valid=0 for all 5 cycles, ins_* stable; packet flows only after ins_ready=1.
- byte_cnt=0 -> no ins_valid, packet passes directly; byte_cnt=7 with DATA_BYTE_WD=4 -> ins_byte_cnt=4, cfg_err one-cycle pulse.
- m_ready toggling 1/0 during a 6-beat packet -> s_ready mirrors m_ready, no beat lost or duplicated, transition to IDLE only on last-beat handshake.
- rst_n low for 1 cycle during beat 2 of PKT -> next cycle state IDLE, busy=0, pkt_cnt=0, rr_ptr=0 (next grant goes to requester 0 when both are valid).
